multi_pit: RTL and testbench

//  Multi-channel programmable interval timer: NUM_CH independent down-counters sharing one

---
 rtl/multi_pit_pkg.sv | 13 +
 rtl/multi_pit_if.sv | 36 +++
 rtl/multi_pit_channel.sv | 60 ++++++
 rtl/multi_pit.sv | 59 +++++
 tb/tb_multi_pit.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multi_pit_pkg.sv
// Shared constants and helpers for the multi-channel interval timer.
// Holds channel mode encodings and the channel-select width helper.
package multi_pit_pkg;

   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Channel-select width; never zero, even for a single channel.
   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multi_pit_if.sv
// Host-side configuration and status bundle of the interval timer.
// master: drives cfg_*, prescale_div, irq_clear; slave: drives irq_pending, irq, active.
interface multi_pit_if #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 16,
   parameter int PRESCALE_W = 8
);
   import multi_pit_pkg::*;

   localparam int CH_W = ch_w(NUM_CH);

   logic                  cfg_we;
   logic [CH_W-1:0]       cfg_ch;
   logic [CNT_W-1:0]      cfg_reload;
   logic                  cfg_periodic;
   logic                  cfg_use_prescale;
   logic                  cfg_enable;
   logic [PRESCALE_W-1:0] prescale_div;
   logic [NUM_CH-1:0]     irq_clear;
   logic [NUM_CH-1:0]     irq_pending;
   logic                  irq;
   logic [NUM_CH-1:0]     active;

   modport master (
      output cfg_we, cfg_ch, cfg_reload, cfg_periodic,
      output cfg_use_prescale, cfg_enable, prescale_div, irq_clear,
      input  irq_pending, irq, active
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_reload, cfg_periodic,
      input  cfg_use_prescale, cfg_enable, prescale_div, irq_clear,
      output irq_pending, irq, active
   );

endinterface

// File: rtl/multi_pit_channel.sv
// One timer channel: down-counter with reload, one-shot/periodic mode, sticky pending.
// Ports: load/config in, shared tick in, clear in; pending and active out.
module multi_pit_channel #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] reload_in,
   input  logic             periodic_in,
   input  logic             use_pre_in,
   input  logic             enable_in,
   input  logic             tick,
   input  logic             clear,
   output logic             pending,
   output logic             active
);
   import multi_pit_pkg::*;

   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] reload;
   logic             mode;
   logic             use_pre;
   logic             step;
   logic             expire;

   assign step   = active & (use_pre ? tick : 1'b1);
   assign expire = step & (count == CNT_W'(1));

   // A write overrides a same-cycle expiry; an expiry overrides a clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         reload  <= '0;
         mode    <= MODE_ONESHOT;
         use_pre <= 1'b0;
         active  <= 1'b0;
         pending <= 1'b0;
      end else if (load) begin
         count   <= reload_in;
         reload  <= reload_in;
         mode    <= periodic_in;
         use_pre <= use_pre_in;
         active  <= enable_in & (reload_in != '0);
         pending <= 1'b0;
      end else if (expire) begin
         pending <= 1'b1;
         if (mode == MODE_PERIODIC) begin
            count <= reload;
         end else begin
            count  <= '0;
            active <= 1'b0;
         end
      end else begin
         if (step)  count   <= count - CNT_W'(1);
         if (clear) pending <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_pit.sv
// Multi-channel interval timer: shared prescaler feeding NUM_CH channels.
// Ports: clk, reset (sync, active-high), bus (slave side of multi_pit_if).
module multi_pit #(
   parameter int NUM_CH     = 4,
   parameter int CNT_W      = 16,
   parameter int PRESCALE_W = 8
) (
   input logic        clk,
   input logic        reset,
   multi_pit_if.slave bus
);
   import multi_pit_pkg::*;

   localparam int CH_W = ch_w(NUM_CH);

   logic [PRESCALE_W-1:0] pcnt;
   logic                  tick;
   logic [NUM_CH-1:0]     load;
   logic [NUM_CH-1:0]     pend;
   logic [NUM_CH-1:0]     act;

   assign tick = (pcnt == bus.prescale_div);

   // >= also catches a live divider change below the current phase.
   always_ff @(posedge clk) begin
      if (reset)
         pcnt <= '0;
      else if (pcnt >= bus.prescale_div)
         pcnt <= '0;
      else
         pcnt <= pcnt + PRESCALE_W'(1);
   end

   // Selects >= NUM_CH match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign load[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

      multi_pit_channel #(
         .CNT_W(CNT_W)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .load        (load[i]),
         .reload_in   (bus.cfg_reload),
         .periodic_in (bus.cfg_periodic),
         .use_pre_in  (bus.cfg_use_prescale),
         .enable_in   (bus.cfg_enable),
         .tick        (tick),
         .clear       (bus.irq_clear[i]),
         .pending     (pend[i]),
         .active      (act[i])
      );
   end

   assign bus.irq_pending = pend;
   assign bus.active      = act;
   assign bus.irq         = |pend;

endmodule

// File: tb/tb_multi_pit.sv
// Self-checking bench for multi_pit against a tick-counting reference model.
// Drives directed scenarios plus random config/clear traffic, checks every cycle.
module tb_multi_pit;

   localparam int D = 4;

   logic clk = 1'b0;
   logic reset;
   int   tests = 0;
   int   fails = 0;

   multi_pit_if #(.NUM_CH(4), .CNT_W(16), .PRESCALE_W(8)) bus ();
   multi_pit_if #(.NUM_CH(3), .CNT_W(16), .PRESCALE_W(8)) bus_b ();

   multi_pit #(.NUM_CH(4), .CNT_W(16), .PRESCALE_W(8)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   multi_pit #(.NUM_CH(3), .CNT_W(16), .PRESCALE_W(8)) dut_b (
      .clk(clk), .reset(reset), .bus(bus_b)
   );

   initial forever #5 clk = ~clk;

   // Model: per channel, the edge of the last write and its config.
   // Steps since write are counted arithmetically from the tick grid.
   int m_w[4];
   int m_r[4];
   bit m_per[4];
   bit m_usep[4];
   bit m_en[4];
   bit m_pend[4];
   int k  = 0;
   int kl = 0;

   function automatic int nsteps(int ch, int kk);
      if (m_usep[ch])
         return (kk + 1) / (D + 1) - (m_w[ch] + 1) / (D + 1);
      return kk - m_w[ch];
   endfunction

   function automatic bit expires(int ch, int kk);
      int n;
      if (!m_en[ch] || m_r[ch] == 0) return 1'b0;
      if (m_usep[ch] && (kk % (D + 1)) != D) return 1'b0;
      n = nsteps(ch, kk);
      if (m_per[ch]) return (n > 0) && (n % m_r[ch] == 0);
      return n == m_r[ch];
   endfunction

   function automatic bit m_active(int ch, int kk);
      return m_en[ch] && m_r[ch] != 0 &&
             (m_per[ch] || nsteps(ch, kk) < m_r[ch]);
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clk_step();
      logic [3:0] ep;
      logic [3:0] ea;
      bit e;
      @(posedge clk);
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            m_w[c] = 0; m_r[c] = 0; m_per[c] = 0;
            m_usep[c] = 0; m_en[c] = 0; m_pend[c] = 0;
         end
         k  = 0;
         kl = 0;
      end else begin
         for (int c = 0; c < 4; c++) begin
            e = expires(c, k);
            if (bus.cfg_we && int'(bus.cfg_ch) == c) begin
               m_w[c]    = k;
               m_r[c]    = int'(bus.cfg_reload);
               m_per[c]  = bus.cfg_periodic;
               m_usep[c] = bus.cfg_use_prescale;
               m_en[c]   = bus.cfg_enable;
               m_pend[c] = 1'b0;
            end else if (e) begin
               m_pend[c] = 1'b1;
            end else if (bus.irq_clear[c]) begin
               m_pend[c] = 1'b0;
            end
         end
         kl = k;
         k++;
      end
      #1;
      for (int c = 0; c < 4; c++) begin
         ep[c] = m_pend[c];
         ea[c] = m_active(c, kl);
      end
      chk("pend", 32'(bus.irq_pending), 32'(ep));
      chk("act",  32'(bus.active), 32'(ea));
      chk("irq",  32'(bus.irq), 32'(|ep));
      bus.cfg_we    = 1'b0;
      bus.irq_clear = '0;
   endtask

   task automatic wr(int ch, int r, bit per, bit usep, bit en);
      bus.cfg_we           = 1'b1;
      bus.cfg_ch           = 2'(ch);
      bus.cfg_reload       = 16'(r);
      bus.cfg_periodic     = per;
      bus.cfg_use_prescale = usep;
      bus.cfg_enable       = en;
      clk_step();
   endtask

   initial begin
      int c;
      bit found;
      reset                  = 1'b1;
      bus.cfg_we             = 1'b0;
      bus.cfg_ch             = '0;
      bus.cfg_reload         = '0;
      bus.cfg_periodic       = 1'b0;
      bus.cfg_use_prescale   = 1'b0;
      bus.cfg_enable         = 1'b0;
      bus.prescale_div       = 8'(D);
      bus.irq_clear          = '0;
      bus_b.cfg_we           = 1'b0;
      bus_b.cfg_ch           = '0;
      bus_b.cfg_reload       = '0;
      bus_b.cfg_periodic     = 1'b0;
      bus_b.cfg_use_prescale = 1'b0;
      bus_b.cfg_enable       = 1'b0;
      bus_b.prescale_div     = 8'(D);
      bus_b.irq_clear        = '0;
      #2;
      repeat (2) clk_step();
      reset = 1'b0;
      chk("reset_pend", 32'(bus.irq_pending), 32'd0);
      chk("reset_act",  32'(bus.active), 32'd0);

      // 1: periodic reload 10, no prescale
      wr(0, 10, 1, 0, 1);
      repeat (9) clk_step();
      chk("t1_pre", 32'(bus.irq_pending[0]), 32'd0);
      clk_step();
      chk("t1_exp", 32'(bus.irq_pending[0]), 32'd1);
      bus.irq_clear = 4'b0001;
      clk_step();
      chk("t1_clr", 32'(bus.irq_pending[0]), 32'd0);
      repeat (8) clk_step();
      chk("t1_pre2", 32'(bus.irq_pending[0]), 32'd0);
      clk_step();
      chk("t1_exp2", 32'(bus.irq_pending[0]), 32'd1);

      // 2: one-shot reload 3 on prescaler (div 4)
      wr(1, 3, 0, 1, 1);
      found = 1'b0;
      c = 0;
      while (!found && c < 30) begin
         clk_step();
         c++;
         found = bus.irq_pending[1];
      end
      chk("t2_lat", 32'(found && c >= 11 && c <= 15), 32'd1);
      chk("t2_act", 32'(bus.active[1]), 32'd0);
      bus.irq_clear = 4'b0010;
      clk_step();
      repeat (100) clk_step();
      chk("t2_none", 32'(bus.irq_pending[1]), 32'd0);

      // 3: clear coincident with expiry keeps pending
      wr(2, 5, 1, 0, 1);
      repeat (5) clk_step();
      chk("t3_exp", 32'(bus.irq_pending[2]), 32'd1);
      repeat (4) clk_step();
      bus.irq_clear = 4'b0100;
      clk_step();
      chk("t3_set_wins", 32'(bus.irq_pending[2]), 32'd1);
      bus.irq_clear = 4'b0100;
      clk_step();
      chk("t3_clr", 32'(bus.irq_pending[2]), 32'd0);

      // 4: rewrite ch0 on its expiry edge
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         if (expires(0, k)) found = 1'b1;
         else clk_step();
      end
      chk("t4_found", 32'(found), 32'd1);
      wr(0, 20, 1, 0, 1);
      chk("t4_wr_wins", 32'(bus.irq_pending[0]), 32'd0);
      repeat (19) clk_step();
      chk("t4_pre", 32'(bus.irq_pending[0]), 32'd0);
      clk_step();
      chk("t4_exp", 32'(bus.irq_pending[0]), 32'd1);

      // 5: four periodic channels 2,3,5,7
      wr(0, 2, 1, 0, 1);
      wr(1, 3, 1, 0, 1);
      wr(2, 5, 1, 0, 1);
      wr(3, 7, 1, 0, 1);
      repeat (210) clk_step();
      chk("t5_irq", 32'(bus.irq), 32'd1);
      chk("t5_act", 32'(bus.active), 32'hF);

      // random config and clear traffic
      repeat (400) begin
         if ($urandom_range(0, 7) == 0) begin
            bus.cfg_we           = 1'b1;
            bus.cfg_ch           = 2'($urandom_range(0, 3));
            bus.cfg_reload       = 16'($urandom_range(0, 12));
            bus.cfg_periodic     = 1'($urandom);
            bus.cfg_use_prescale = 1'($urandom);
            bus.cfg_enable       = ($urandom_range(0, 3) != 0);
         end
         if ($urandom_range(0, 3) == 0)
            bus.irq_clear = 4'($urandom);
         clk_step();
      end

      // 6: reset mid-count, then out-of-range write on 3-channel instance
      wr(0, 9, 1, 0, 1);
      repeat (3) clk_step();
      reset = 1'b1;
      clk_step();
      reset = 1'b0;
      chk("t6_pend", 32'(bus.irq_pending), 32'd0);
      chk("t6_act",  32'(bus.active), 32'd0);
      chk("t6_irq",  32'(bus.irq), 32'd0);
      bus_b.cfg_we     = 1'b1;
      bus_b.cfg_ch     = 2'd3;
      bus_b.cfg_reload = 16'd1;
      bus_b.cfg_periodic = 1'b1;
      bus_b.cfg_enable = 1'b1;
      clk_step();
      bus_b.cfg_we = 1'b0;
      repeat (4) clk_step();
      chk("t6_bad_pend", 32'(bus_b.irq_pending), 32'd0);
      chk("t6_bad_act",  32'(bus_b.active), 32'd0);
      bus_b.cfg_we = 1'b1;
      bus_b.cfg_ch = 2'd2;
      clk_step();
      bus_b.cfg_we = 1'b0;
      chk("t6_ok_act", 32'(bus_b.active), 32'b100);
      clk_step();
      chk("t6_ok_pend", 32'(bus_b.irq_pending), 32'b100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
